// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table stimulus and checking engine
//
// Purpose:
//   Steps an N_IN-bit code through 0..NUM_VEC-1, holds each code for DWELL
//   cycles, samples the 1-bit response of the block under test on the last
//   cycle of every dwell window and compares it with the golden table
//   EXPECTED. Reports the captured table, the number of mismatching codes
//   and the first failing code.
//
// Configuration macro:
//   STOP_ON_FAIL_EN - when defined, the first mismatch ends the sweep on the
//                     edge that detects it (vec_out keeps the failing code).
//                     When undefined, the full sweep always runs.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous active-high reset
//   start      in   1          begin sweep (honoured in IDLE or DONE)
//   abort      in   1          cancel sweep (honoured in DRIVE)
//   vec_out    out  N_IN       stimulus code
//   y_in       in   1          response of the block under test
//   busy       out  1          sweep in progress
//   done       out  1          sweep finished, held until next start or rst
//   pass       out  1          done with zero mismatches
//   mism_cnt   out  N_IN+1     number of mismatching codes
//   captured   out  2**N_IN    bit k = response sampled for code k
//   first_fail out  N_IN       first mismatching code (valid with ff_vld)
//   ff_vld     out  1          at least one mismatch recorded

module truth_table_sweeper #(
    parameter int                N_IN     = 4,
    parameter int                NUM_VEC  = 2 ** N_IN,
    parameter int                DWELL    = 10,
    parameter logic [2**N_IN-1:0] EXPECTED = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [N_IN-1:0]      vec_out,
    input  logic                 y_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        mism_cnt,
    output logic [2**N_IN-1:0]   captured,
    output logic [N_IN-1:0]      first_fail,
    output logic                 ff_vld
);

    localparam int NV = 2 ** N_IN;
    // Dwell counter needs to reach DWELL-1; keep at least one bit for DWELL=1.
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [N_IN-1:0] LAST_VEC   = N_IN'(NUM_VEC - 1);
    localparam logic [DW-1:0]   LAST_DWELL = DW'(DWELL - 1);
    localparam logic [N_IN-1:0] VEC_ONE    = N_IN'(1);
    localparam logic [DW-1:0]   DWELL_ONE  = DW'(1);
    localparam logic [N_IN:0]   CNT_ONE    = (N_IN + 1)'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [N_IN:0]   mism_q, mism_d;
    logic [NV-1:0]   cap_q, cap_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            ffv_q, ffv_d;
    logic            mismatch;

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        dwell_d  = dwell_q;
        mism_d   = mism_q;
        cap_d    = cap_q;
        ff_d     = ff_q;
        ffv_d    = ffv_q;
        mismatch = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                // Results stay visible after abort or completion and are
                // only wiped when a new sweep begins.
                if (start) begin
                    state_d = S_DRIVE;
                    vec_d   = '0;
                    dwell_d = '0;
                    mism_d  = '0;
                    cap_d   = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                end
            end

            S_DRIVE: begin
                if (abort) begin
                    // Abort beats a coinciding final sample: nothing is
                    // captured on this edge and done never rises.
                    state_d = S_IDLE;
                    vec_d   = '0;
                    dwell_d = '0;
                end else if (dwell_q == LAST_DWELL) begin
                    mismatch      = (y_in != EXPECTED[vec_q]);
                    cap_d[vec_q]  = y_in;
                    dwell_d       = '0;
                    if (mismatch) begin
                        mism_d = mism_q + CNT_ONE;
                        if (!ffv_q) begin
                            ff_d  = vec_q;
                            ffv_d = 1'b1;
                        end
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d = vec_q + VEC_ONE;
                    end
`ifdef STOP_ON_FAIL_EN
                    if (mismatch) begin
                        state_d = S_DONE;
                        vec_d   = vec_q;
                    end
`endif
                end else begin
                    dwell_d = dwell_q + DWELL_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                vec_d   = '0;
                dwell_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            dwell_q <= '0;
            mism_q  <= '0;
            cap_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            dwell_q <= dwell_d;
            mism_q  <= mism_d;
            cap_q   <= cap_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
        end
    end

    assign vec_out    = vec_q;
    assign busy       = (state_q == S_DRIVE);
    assign done       = (state_q == S_DONE);
    assign pass       = done && (mism_q == '0);
    assign mism_cnt   = mism_q;
    assign captured   = cap_q;
    assign first_fail = ff_q;
    assign ff_vld     = ffv_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - directed bench for truth_table_sweeper
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst, start, abort, fault;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Main instance: 4-bit parity table, full sweep, DWELL=10
    logic [3:0]  vec0, ff0;
    logic        y0, busy0, done0, pass0, ffv0;
    logic [4:0]  mism0;
    logic [15:0] cap0;
    assign y0 = fault ? 1'b0 : ^vec0;

    truth_table_sweeper #(.N_IN(4), .NUM_VEC(16), .DWELL(10), .EXPECTED(16'h6996)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_out(vec0), .y_in(y0),
        .busy(busy0), .done(done0), .pass(pass0), .mism_cnt(mism0), .captured(cap0),
        .first_fail(ff0), .ff_vld(ffv0));

    // Partial sweep instance: NUM_VEC=5
    logic [3:0]  vec5, ff5;
    logic        y5, busy5, done5, pass5, ffv5;
    logic [4:0]  mism5;
    logic [15:0] cap5;
    assign y5 = fault ? 1'b0 : ^vec5;

    truth_table_sweeper #(.N_IN(4), .NUM_VEC(5), .DWELL(10), .EXPECTED(16'h6996)) dut5 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_out(vec5), .y_in(y5),
        .busy(busy5), .done(done5), .pass(pass5), .mism_cnt(mism5), .captured(cap5),
        .first_fail(ff5), .ff_vld(ffv5));

    // DWELL=1 instance: 2-bit XOR table
    logic [1:0]  vec1, ff1;
    logic        y1, busy1, done1, pass1, ffv1;
    logic [2:0]  mism1;
    logic [3:0]  cap1;
    assign y1 = fault ? 1'b0 : ^vec1;

    truth_table_sweeper #(.N_IN(2), .NUM_VEC(4), .DWELL(1), .EXPECTED(4'b0110)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_out(vec1), .y_in(y1),
        .busy(busy1), .done(done1), .pass(pass1), .mism_cnt(mism1), .captured(cap1),
        .first_fail(ff1), .ff_vld(ffv1));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; fault = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        checks++;
        if ({vec0, busy0, done0, pass0, mism0, cap0, ff0, ffv0} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got vec=%h busy=%b done=%b pass=%b mism=%0d cap=%h ff=%h ffv=%b, want all zero",
                     vec0, busy0, done0, pass0, mism0, cap0, ff0, ffv0);
        end
        checks++;
        if ({busy5, done5, busy1, done1} !== 4'b0) begin
            failures++;
            $display("FAIL reset_others: got %b, want 0000", {busy5, done5, busy1, done1});
        end
    endtask

    task automatic test_parity();
        int n;
        logic [3:0] ev;
        fault = 1'b0;
        pulse_start();
        n = 0;
        while (done0 !== 1'b1 && n < 1000) begin
            ev = 4'(n / 10);
            checks++;
            if (vec0 !== ev || busy0 !== 1'b1) begin
                failures++;
                $display("FAIL parity_step n=%0d: got vec=%h busy=%b, want vec=%h busy=1", n, vec0, busy0, ev);
            end
            if (n < 4) begin
                checks++;
                if (vec1 !== 2'(n) || done1 !== 1'b0) begin
                    failures++;
                    $display("FAIL dwell1_step n=%0d: got vec=%h done=%b, want vec=%h done=0", n, vec1, done1, 2'(n));
                end
            end
            if (n == 4) begin
                checks++;
                if (done1 !== 1'b1 || pass1 !== 1'b1 || cap1 !== 4'b0110 || vec1 !== 2'd3) begin
                    failures++;
                    $display("FAIL dwell1_done: got done=%b pass=%b cap=%b vec=%h, want 1 1 0110 3", done1, pass1, cap1, vec1);
                end
            end
            if (n == 49) begin
                checks++;
                if (done5 !== 1'b0 || vec5 !== 4'd4) begin
                    failures++;
                    $display("FAIL partial_pre: got done=%b vec=%h, want done=0 vec=4", done5, vec5);
                end
            end
            if (n == 50) begin
                checks++;
                if (done5 !== 1'b1 || pass5 !== 1'b1 || cap5 !== 16'h0016 || vec5 !== 4'd4 || busy5 !== 1'b0) begin
                    failures++;
                    $display("FAIL partial_done: got done=%b pass=%b cap=%h vec=%h busy=%b, want 1 1 0016 4 0",
                             done5, pass5, cap5, vec5, busy5);
                end
            end
            cyc();
            n++;
        end
        checks++;
        if (n !== 160) begin
            failures++;
            $display("FAIL parity_latency: got %0d, want 160", n);
        end
        checks++;
        if (cap0 !== 16'h6996 || mism0 !== 5'd0 || ffv0 !== 1'b0 || pass0 !== 1'b1 || vec0 !== 4'hF || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL parity_result: got cap=%h mism=%0d ffv=%b pass=%b vec=%h busy=%b, want 6996 0 0 1 f 0",
                     cap0, mism0, ffv0, pass0, vec0, busy0);
        end
    endtask

    task automatic test_stuck();
        int n;
        int exp_n;
        logic [4:0] exp_mism;
        logic [3:0] exp_vec;
`ifdef STOP_ON_FAIL_EN
        exp_n = 20; exp_mism = 5'd1; exp_vec = 4'd1;
`else
        exp_n = 160; exp_mism = 5'd8; exp_vec = 4'hF;
`endif
        fault = 1'b1;
        pulse_start();
        n = 0;
        while (done0 !== 1'b1 && n < 1000) begin
            cyc();
            n++;
        end
        checks++;
        if (n !== exp_n) begin
            failures++;
            $display("FAIL stuck_latency: got %0d, want %0d", n, exp_n);
        end
        checks++;
        if (mism0 !== exp_mism || ff0 !== 4'd1 || ffv0 !== 1'b1 || pass0 !== 1'b0 || cap0 !== 16'h0000 || vec0 !== exp_vec) begin
            failures++;
            $display("FAIL stuck_result: got mism=%0d ff=%h ffv=%b pass=%b cap=%h vec=%h, want %0d 1 1 0 0000 %h",
                     mism0, ff0, ffv0, pass0, cap0, vec0, exp_mism, exp_vec);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        fault = 1'b0;
        pulse_start();
        checks++;
        if (busy0 !== 1'b1 || done0 !== 1'b0 || mism0 !== 5'd0 || ffv0 !== 1'b0 || cap0 !== 16'h0 || vec0 !== 4'd0) begin
            failures++;
            $display("FAIL restart_clear: got busy=%b done=%b mism=%0d ffv=%b cap=%h vec=%h, want 1 0 0 0 0000 0",
                     busy0, done0, mism0, ffv0, cap0, vec0);
        end
        n = 0;
        while (done0 !== 1'b1 && n < 1000) begin
            cyc();
            n++;
        end
        checks++;
        if (n !== 160 || pass0 !== 1'b1 || cap0 !== 16'h6996) begin
            failures++;
            $display("FAIL restart_result: got n=%0d pass=%b cap=%h, want 160 1 6996", n, pass0, cap0);
        end
    endtask

    task automatic test_abort();
        fault = 1'b0;
        pulse_start();
        repeat (35) cyc();
        pulse_start();
        checks++;
        if (vec0 !== 4'd3 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL start_while_busy: got vec=%h busy=%b, want 3 1", vec0, busy0);
        end
        repeat (19) cyc();
        checks++;
        if (vec0 !== 4'd5 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL abort_setup: got vec=%h busy=%b, want 5 1", vec0, busy0);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        checks++;
        if (vec0 !== 4'd0 || busy0 !== 1'b0 || done0 !== 1'b0 || pass0 !== 1'b0 || cap0 !== 16'h0016 || mism0 !== 5'd0) begin
            failures++;
            $display("FAIL abort_result: got vec=%h busy=%b done=%b pass=%b cap=%h mism=%0d, want 0 0 0 0 0016 0",
                     vec0, busy0, done0, pass0, cap0, mism0);
        end
        cyc();
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || vec0 !== 4'd0) begin
            failures++;
            $display("FAIL abort_idle_hold: got busy=%b done=%b vec=%h, want 0 0 0", busy0, done0, vec0);
        end
    endtask

    task automatic test_abort_final_sample();
        fault = 1'b0;
        pulse_start();
        repeat (49) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        checks++;
        if (done5 !== 1'b0 || busy5 !== 1'b0 || vec5 !== 4'd0 || cap5 !== 16'h0006) begin
            failures++;
            $display("FAIL abort_beats_final: got done=%b busy=%b vec=%h cap=%h, want 0 0 0 0006", done5, busy5, vec5, cap5);
        end
        checks++;
        if (busy0 !== 1'b0 || cap0 !== 16'h0006 || vec0 !== 4'd0) begin
            failures++;
            $display("FAIL abort_mid_window: got busy=%b cap=%h vec=%h, want 0 0006 0", busy0, cap0, vec0);
        end
    endtask

    task automatic test_mid_reset();
        fault = 1'b1;
        pulse_start();
        repeat (36) cyc();
        rst = 1'b1;
        cyc(); cyc();
        checks++;
        if ({vec0, busy0, done0, pass0, mism0, cap0, ff0, ffv0} !== '0) begin
            failures++;
            $display("FAIL mid_reset: got vec=%h busy=%b done=%b mism=%0d cap=%h ff=%h ffv=%b, want all zero",
                     vec0, busy0, done0, mism0, cap0, ff0, ffv0);
        end
        rst = 1'b0;
        fault = 1'b0;
        pulse_start();
        checks++;
        if (busy0 !== 1'b1 || vec0 !== 4'd0 || mism0 !== 5'd0) begin
            failures++;
            $display("FAIL post_reset_start: got busy=%b vec=%h mism=%0d, want 1 0 0", busy0, vec0, mism0);
        end
        repeat (10) cyc();
        checks++;
        if (vec0 !== 4'd1 || cap0 !== 16'h0000) begin
            failures++;
            $display("FAIL post_reset_step: got vec=%h cap=%h, want 1 0000", vec0, cap0);
        end
    endtask

    initial begin
        test_reset();
        test_parity();
        test_stuck();
        test_back_to_back();
        test_abort();
        test_abort_final_sample();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
